// File: rtl/bsg_manycore_io_responder_if.sv
// IO-link bundle between the array column and the responder: request (array -> responder) and return (responder -> array).
// Encodings: req_op 0 = STORE, 1 = LOAD; rsp_type 0 = STORE_ACK, 1 = LOAD.
interface bsg_manycore_io_responder_if #(
    parameter int addr_width_p    = 16,
    parameter int data_width_p    = 32,
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 4,
    parameter int load_id_width_p = 5
);
    logic                         req_vld;
    logic                         req_rdy;
    logic [addr_width_p-1:0]      req_addr;
    logic                         req_op;
    logic [data_width_p/8-1:0]    req_mask;
    logic [data_width_p-1:0]      req_dat;
    logic [x_cord_width_p-1:0]    req_src_x;
    logic [y_cord_width_p-1:0]    req_src_y;
    logic [load_id_width_p-1:0]   req_load_id;

    logic                         rsp_vld;
    logic                         rsp_rdy;
    logic                         rsp_type;
    logic [data_width_p-1:0]      rsp_dat;
    logic [load_id_width_p-1:0]   rsp_load_id;
    logic [x_cord_width_p-1:0]    rsp_dst_x;
    logic [y_cord_width_p-1:0]    rsp_dst_y;
    logic [x_cord_width_p-1:0]    rsp_src_x;
    logic [y_cord_width_p-1:0]    rsp_src_y;

    modport master (
        output req_vld, req_addr, req_op, req_mask, req_dat, req_src_x, req_src_y, req_load_id,
        input  req_rdy,
        input  rsp_vld, rsp_type, rsp_dat, rsp_load_id, rsp_dst_x, rsp_dst_y, rsp_src_x, rsp_src_y,
        output rsp_rdy
    );

    modport slave (
        input  req_vld, req_addr, req_op, req_mask, req_dat, req_src_x, req_src_y, req_load_id,
        output req_rdy,
        output rsp_vld, rsp_type, rsp_dat, rsp_load_id, rsp_dst_x, rsp_dst_y, rsp_src_x, rsp_src_y,
        input  rsp_rdy
    );
endinterface

// File: rtl/bsg_manycore_io_responder.sv
// Remote load/store responder for one IO column: 2-entry request FIFO -> memory access -> 1-entry response register.
// Response valid two edges after the request is driven; with return stalled it absorbs 3 requests then drops req_rdy.
module bsg_manycore_io_responder #(
    parameter int addr_width_p    = 16,
    parameter int data_width_p    = 32,
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 4,
    parameter int load_id_width_p = 5,
    parameter int els_p           = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    bsg_manycore_io_responder_if.slave link_sif,
    output logic [31:0]               store_count_o,
    output logic [31:0]               load_count_o,
    output logic [15:0]               oor_count_o
);
    localparam int mask_w_lp = data_width_p / 8;
    localparam int idx_w_lp  = $clog2(els_p);
    localparam logic [addr_width_p:0] els_cmp_lp = (addr_width_p + 1)'(els_p);

    typedef struct packed {
        logic [addr_width_p-1:0]    addr;
        logic                       op;
        logic [mask_w_lp-1:0]       mask;
        logic [data_width_p-1:0]    dat;
        logic [x_cord_width_p-1:0]  src_x;
        logic [y_cord_width_p-1:0]  src_y;
        logic [load_id_width_p-1:0] load_id;
    } req_t;

    req_t                       req_in, head;
    req_t                       fifo_q [2];
    logic                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       rdy_en_q;
    logic                       enq, issue, rsp_deq, head_in_range;
    logic [idx_w_lp-1:0]        head_idx;

    logic                       s2_vld_q, s2_vld_d, s2_load_q, s2_oor_q;
    logic [x_cord_width_p-1:0]  s2_x_q;
    logic [y_cord_width_p-1:0]  s2_y_q;
    logic [load_id_width_p-1:0] s2_id_q;
    logic [data_width_p-1:0]    rd_dat_q;
    logic [data_width_p-1:0]    mem_q [els_p];

    logic [31:0]                store_cnt_q, store_cnt_d, load_cnt_q, load_cnt_d;
    logic [15:0]                oor_cnt_q, oor_cnt_d;

    always_comb begin
        req_in.addr    = link_sif.req_addr;
        req_in.op      = link_sif.req_op;
        req_in.mask    = link_sif.req_mask;
        req_in.dat     = link_sif.req_dat;
        req_in.src_x   = link_sif.req_src_x;
        req_in.src_y   = link_sif.req_src_y;
        req_in.load_id = link_sif.req_load_id;
    end

    // Ready comes from the registered count only, so a full FIFO never sees enqueue and dequeue together.
    assign link_sif.req_rdy = rdy_en_q & (cnt_q != 2'd2);
    assign enq              = link_sif.req_vld & link_sif.req_rdy;
    assign rsp_deq          = s2_vld_q & link_sif.rsp_rdy;
    assign issue            = (cnt_q != 2'd0) & (~s2_vld_q | rsp_deq);
    assign head             = fifo_q[rd_ptr_q];
    assign head_in_range    = ({1'b0, head.addr} < els_cmp_lp);
    assign head_idx         = head.addr[idx_w_lp-1:0];

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        s2_vld_d = s2_vld_q;
        if (enq)   wr_ptr_d = ~wr_ptr_q;
        if (issue) rd_ptr_d = ~rd_ptr_q;
        case ({enq, issue})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (issue)        s2_vld_d = 1'b1;
        else if (rsp_deq) s2_vld_d = 1'b0;
    end

    always_comb begin
        store_cnt_d = store_cnt_q;
        load_cnt_d  = load_cnt_q;
        oor_cnt_d   = oor_cnt_q;
        if (rsp_deq) begin
            if (s2_load_q) load_cnt_d  = load_cnt_q + 32'd1;
            else           store_cnt_d = store_cnt_q + 32'd1;
            if (s2_oor_q && (oor_cnt_q != 16'hFFFF)) oor_cnt_d = oor_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            rdy_en_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_load_q   <= 1'b0;
            s2_oor_q    <= 1'b0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            s2_id_q     <= '0;
            store_cnt_q <= 32'd0;
            load_cnt_q  <= 32'd0;
            oor_cnt_q   <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rdy_en_q    <= 1'b1;
            s2_vld_q    <= s2_vld_d;
            store_cnt_q <= store_cnt_d;
            load_cnt_q  <= load_cnt_d;
            oor_cnt_q   <= oor_cnt_d;
            if (issue) begin
                s2_load_q <= head.op;
                s2_oor_q  <= ~head_in_range;
                s2_x_q    <= head.src_x;
                s2_y_q    <= head.src_y;
                s2_id_q   <= head.load_id;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) fifo_q[wr_ptr_q] <= req_in;
    end

    // Memory is never reset; accesses are serialized here, so a store is visible to the next load.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            if (!head.op && head_in_range) begin
                for (int b = 0; b < mask_w_lp; b++) begin
                    if (head.mask[b]) mem_q[head_idx][8*b +: 8] <= head.dat[8*b +: 8];
                end
            end
            rd_dat_q <= mem_q[head_idx];
        end
    end

    always_comb begin
        link_sif.rsp_dat = '0;
        if (s2_vld_q && s2_load_q)
            link_sif.rsp_dat = s2_oor_q ? data_width_p'(32'hDEAD_BEEF) : rd_dat_q;
    end

    assign link_sif.rsp_vld     = s2_vld_q;
    assign link_sif.rsp_type    = s2_load_q;
    assign link_sif.rsp_load_id = s2_id_q;
    assign link_sif.rsp_dst_x   = s2_x_q;
    assign link_sif.rsp_dst_y   = s2_y_q;
    assign link_sif.rsp_src_x   = my_x_i;
    assign link_sif.rsp_src_y   = my_y_i;

    assign store_count_o = store_cnt_q;
    assign load_count_o  = load_cnt_q;
    assign oor_count_o   = oor_cnt_q;
endmodule
